// File: rtl/lib_local_arb_pkg.sv
// lib_local_arb_pkg
// Shared definitions for the local register port arbiter:
//   - state_t  : arbiter FSM state encoding
//   - CNT_W    : read-latency counter width (covers RD_LAT up to 8)
//   - clog2()  : index width for a requester count (minimum 1 bit)
package lib_local_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  localparam int CNT_W = 3;

  // Bits needed to index n items; never less than one bit.
  function automatic int clog2(input int n);
    int w;
    w = 0;
    for (int v = n - 1; v > 0; v = v >> 1) begin
      w = w + 1;
    end
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/lib_local_arb_if.sv
// lib_local_arb_if
// Bundles the requester-side handshake and the local register port.
//   master : environment side (requesters drive req_*, register file drives loc_rdata)
//   slave  : arbiter side
// Signals: req_valid/req_wr/req_addr/req_wdata (packed per requester), req_ready,
//          rsp_valid, rsp_rdata, loc_addr, loc_wdata, loc_wen, loc_ren, loc_rdata.
interface lib_local_arb_if #(
  parameter int NUM_REQ = 2,
  parameter int AW      = 12,
  parameter int DW      = 32
);

  logic [NUM_REQ-1:0]    req_valid;
  logic [NUM_REQ-1:0]    req_wr;
  logic [NUM_REQ*AW-1:0] req_addr;
  logic [NUM_REQ*DW-1:0] req_wdata;
  logic [NUM_REQ-1:0]    req_ready;
  logic [NUM_REQ-1:0]    rsp_valid;
  logic [DW-1:0]         rsp_rdata;
  logic [AW-1:0]         loc_addr;
  logic [DW-1:0]         loc_wdata;
  logic                  loc_wen;
  logic                  loc_ren;
  logic [DW-1:0]         loc_rdata;

  modport master (
    output req_valid, req_wr, req_addr, req_wdata, loc_rdata,
    input  req_ready, rsp_valid, rsp_rdata, loc_addr, loc_wdata, loc_wen, loc_ren
  );

  modport slave (
    input  req_valid, req_wr, req_addr, req_wdata, loc_rdata,
    output req_ready, rsp_valid, rsp_rdata, loc_addr, loc_wdata, loc_wen, loc_ren
  );

endinterface

// File: rtl/lib_local_arb_rr_pick.sv
// lib_rr_pick
// Combinational requester picker.
//   req        : request vector
//   last_grant : index granted most recently
//   grant      : one-hot winner
//   grant_idx  : winner index
//   any_req    : at least one request present
// Default: round-robin, search starts at last_grant+1 with wrap.
// With LIB_LOCAL_ARB_FIXED_PRIO_EN defined: lowest index always wins and
// last_grant is ignored.
module lib_rr_pick
  import lib_local_arb_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int IW      = clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IW-1:0]      last_grant,
  output logic [NUM_REQ-1:0] grant,
  output logic [IW-1:0]      grant_idx,
  output logic               any_req
);

  logic found_s;

  // Winner search; the first hit in search order sticks.
  always_comb begin
    grant_idx = '0;
    found_s   = 1'b0;
    any_req   = |req;
`ifdef LIB_LOCAL_ARB_FIXED_PRIO_EN
    for (int i = 0; i < NUM_REQ; i++) begin
      if (req[i] && !found_s) begin
        found_s   = 1'b1;
        grant_idx = IW'(i);
      end else begin
        found_s   = found_s;
      end
    end
`else
    for (int k = 1; k <= NUM_REQ; k++) begin
      int cand;
      cand = (int'(last_grant) + k) % NUM_REQ;
      if (req[cand] && !found_s) begin
        found_s   = 1'b1;
        grant_idx = IW'(cand);
      end else begin
        found_s   = found_s;
      end
    end
`endif
    if (any_req) begin
      grant = NUM_REQ'(1) << grant_idx;
    end else begin
      grant = '0;
    end
  end

endmodule

// File: rtl/lib_local_arb.sv
// lib_local_arb
// Round-robin arbiter sharing one local register port between NUM_REQ
// requesters. Single-beat accesses are serialised as IDLE -> ISSUE ->
// (WAIT) -> RESP; a one-cycle rsp_valid pulse goes back to the winner.
// Ports:
//   S_AXI_ACLK   : clock
//   S_AXI_ARESET : synchronous active-high reset
//   bus          : lib_local_arb_if.slave (requester handshake + loc_* port)
// Build option: LIB_LOCAL_ARB_FIXED_PRIO_EN selects fixed lowest-index
// priority instead of round-robin (see lib_rr_pick).
module lib_local_arb
  import lib_local_arb_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int AW      = 12,
  parameter int DW      = 32,
  parameter int RD_LAT  = 1
) (
  input  logic             S_AXI_ACLK,
  input  logic             S_AXI_ARESET,
  lib_local_arb_if.slave   bus
);

  localparam int IW = clog2(NUM_REQ);

  state_t               state_r, state_nxt_s;
  logic [IW-1:0]        last_grant_r, idx_r;
  logic                 wr_r;
  logic [CNT_W-1:0]     cnt_r;
  logic [NUM_REQ-1:0]   pick_grant_s;
  logic [IW-1:0]        pick_idx_s;
  logic                 pick_any_s;

  logic [NUM_REQ-1:0]   req_ready_r, rsp_valid_r;
  logic [DW-1:0]        rsp_rdata_r, loc_wdata_r;
  logic [AW-1:0]        loc_addr_r;
  logic                 loc_wen_r, loc_ren_r;

  lib_rr_pick #(.NUM_REQ(NUM_REQ), .IW(IW)) u_pick (
    .req        (bus.req_valid),
    .last_grant (last_grant_r),
    .grant      (pick_grant_s),
    .grant_idx  (pick_idx_s),
    .any_req    (pick_any_s)
  );

  // FSM state register
  always_ff @(posedge S_AXI_ACLK) begin
    if (S_AXI_ARESET) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next-state decode
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (pick_any_s) state_nxt_s = ST_ISSUE;
        else            state_nxt_s = ST_IDLE;
      end
      ST_ISSUE: begin
        if (wr_r) state_nxt_s = ST_RESP;
        else      state_nxt_s = ST_WAIT;
      end
      ST_WAIT: begin
        if (cnt_r == '0) state_nxt_s = ST_RESP;
        else             state_nxt_s = ST_WAIT;
      end
      ST_RESP: state_nxt_s = ST_IDLE;
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Request latches, latency counter and registered outputs. The outputs of
  // a state are loaded on the edge that enters it, so loc_addr/loc_wdata
  // double as the payload latches and hold their value outside ISSUE.
  always_ff @(posedge S_AXI_ACLK) begin
    if (S_AXI_ARESET) begin
      last_grant_r <= IW'(NUM_REQ - 1);
      idx_r        <= '0;
      wr_r         <= 1'b0;
      cnt_r        <= '0;
      req_ready_r  <= '0;
      rsp_valid_r  <= '0;
      rsp_rdata_r  <= '0;
      loc_addr_r   <= '0;
      loc_wdata_r  <= '0;
      loc_wen_r    <= 1'b0;
      loc_ren_r    <= 1'b0;
    end else begin
      req_ready_r <= '0;
      rsp_valid_r <= '0;
      loc_wen_r   <= 1'b0;
      loc_ren_r   <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (pick_any_s) begin
            idx_r        <= pick_idx_s;
            wr_r         <= bus.req_wr[pick_idx_s];
            last_grant_r <= pick_idx_s;
            loc_addr_r   <= bus.req_addr[pick_idx_s*AW +: AW];
            loc_wdata_r  <= bus.req_wdata[pick_idx_s*DW +: DW];
            loc_wen_r    <= bus.req_wr[pick_idx_s];
            loc_ren_r    <= ~bus.req_wr[pick_idx_s];
            req_ready_r  <= pick_grant_s;
          end
        end
        ST_ISSUE: begin
          if (wr_r) begin
            rsp_valid_r <= NUM_REQ'(1) << idx_r;
            rsp_rdata_r <= '0;
          end else begin
            cnt_r <= CNT_W'(RD_LAT - 1);
          end
        end
        ST_WAIT: begin
          if (cnt_r == '0) begin
            rsp_valid_r <= NUM_REQ'(1) << idx_r;
            rsp_rdata_r <= bus.loc_rdata;
          end else begin
            cnt_r <= cnt_r - CNT_W'(1);
          end
        end
        ST_RESP: begin
          cnt_r <= cnt_r;
        end
        default: begin
          cnt_r <= '0;
        end
      endcase
    end
  end

  assign bus.req_ready = req_ready_r;
  assign bus.rsp_valid = rsp_valid_r;
  assign bus.rsp_rdata = rsp_rdata_r;
  assign bus.loc_addr  = loc_addr_r;
  assign bus.loc_wdata = loc_wdata_r;
  assign bus.loc_wen   = loc_wen_r;
  assign bus.loc_ren   = loc_ren_r;

endmodule

// File: tb/tb_lib_local_arb.sv
// tb_lib_local_arb
// Self-checking bench for lib_local_arb (NUM_REQ=4, RD_LAT=3). A local
// register file with RD_LAT read latency sits on the loc_* port. A
// transaction-level reference model (grant rule + latency rules +
// scoreboard memory) predicts every output each cycle.
// Honours LIB_LOCAL_ARB_FIXED_PRIO_EN for the expected grant order.
module tb_lib_local_arb;

  localparam int N      = 4;
  localparam int AW     = 12;
  localparam int DW     = 32;
  localparam int RD_LAT = 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  lib_local_arb_if #(.NUM_REQ(N), .AW(AW), .DW(DW)) bus ();

  lib_local_arb #(.NUM_REQ(N), .AW(AW), .DW(DW), .RD_LAT(RD_LAT)) dut (
    .S_AXI_ACLK   (clk),
    .S_AXI_ARESET (rst),
    .bus          (bus)
  );

  // Local register file; read data is valid RD_LAT cycles after loc_ren,
  // random garbage otherwise.
  bit   [DW-1:0] lmem  [0:(1<<AW)-1];
  logic [DW-1:0] rpipe [0:RD_LAT-1];
  always @(posedge clk) begin
    if (bus.loc_wen) lmem[bus.loc_addr] <= bus.loc_wdata;
    rpipe[0] <= bus.loc_ren ? lmem[bus.loc_addr] : DW'($urandom);
    for (int k = 1; k < RD_LAT; k++) rpipe[k] <= rpipe[k-1];
  end
  assign bus.loc_rdata = rpipe[RD_LAT-1];

  int n_vec = 0, n_bad = 0, cyc = 0, n_rsp = 0;
  bit r_pend [N];
  bit r_wr [N];
  logic [AW-1:0] r_addr [N];
  logic [DW-1:0] r_data [N];
  bit r_rst = 1'b0, rand_mode = 1'b0;
  int cnt_rdy [N];
  int cnt_rsp [N];
  bit [DW-1:0] sb [0:(1<<AW)-1];

  // reference model state
  bit m_busy = 1'b0, m_in_idle = 1'b1, m_rst_seen = 1'b0, m_wr;
  int m_idx, m_issue_cyc, m_rsp_cyc, m_last = N - 1;
  logic [AW-1:0] m_addr, m_loc_addr = '0;
  logic [DW-1:0] m_wdata, m_exp_rd, m_loc_wdata = '0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int pick(input bit [N-1:0] v, input int last);
`ifdef LIB_LOCAL_ARB_FIXED_PRIO_EN
    for (int i = 0; i < N; i++) if (v[i]) return i;
`else
    for (int k = 1; k <= N; k++) if (v[(last + k) % N]) return (last + k) % N;
`endif
    return -1;
  endfunction

  task automatic check_outputs();
    bit issue, resp;
    if (m_rst_seen) begin
      m_busy = 1'b0; m_last = N - 1; m_loc_addr = '0; m_loc_wdata = '0;
    end
    m_in_idle = !m_busy;
    issue = m_busy && (cyc == m_issue_cyc);
    resp  = m_busy && (cyc == m_rsp_cyc);
    if (issue) begin m_loc_addr = m_addr; m_loc_wdata = m_wdata; end
    chk("req_ready", bus.req_ready, issue ? (64'd1 << m_idx) : 64'd0);
    chk("rsp_valid", bus.rsp_valid, resp ? (64'd1 << m_idx) : 64'd0);
    chk("loc_wen",   bus.loc_wen, issue && m_wr);
    chk("loc_ren",   bus.loc_ren, issue && !m_wr);
    chk("loc_addr",  bus.loc_addr, m_loc_addr);
    chk("loc_wdata", bus.loc_wdata, m_loc_wdata);
    chk("wen_ren_excl", bus.loc_wen & bus.loc_ren, 64'd0);
    if (resp) chk("rsp_rdata", bus.rsp_rdata, m_wr ? 64'd0 : 64'(m_exp_rd));
    if (m_rst_seen) chk("rsp_rdata_rst", bus.rsp_rdata, 64'd0);
    if (resp) begin m_busy = 1'b0; n_rsp++; end
    m_rst_seen = 1'b0;
  endtask

  task automatic model_sample();
    bit [N-1:0] v;
    int g;
    for (int i = 0; i < N; i++) v[i] = r_pend[i];
    if (r_rst) begin
      m_rst_seen = 1'b1;
    end else if (m_in_idle && v != '0) begin
      g = pick(v, m_last);
      m_busy = 1'b1; m_idx = g; m_wr = r_wr[g]; m_addr = r_addr[g]; m_wdata = r_data[g];
      m_issue_cyc = cyc + 1;
      m_rsp_cyc   = r_wr[g] ? cyc + 2 : cyc + 2 + RD_LAT;
      m_last = g;
      if (r_wr[g]) sb[r_addr[g]] = r_data[g];
      else         m_exp_rd = sb[r_addr[g]];
    end
  endtask

  task automatic drive();
    rst = r_rst;
    for (int i = 0; i < N; i++) begin
      bus.req_valid[i] = r_pend[i];
      bus.req_wr[i]    = r_wr[i];
      bus.req_addr[i*AW +: AW]  = r_addr[i];
      bus.req_wdata[i*DW +: DW] = r_data[i];
    end
  endtask

  task automatic post(input int i, input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
    r_pend[i] = 1'b1; r_wr[i] = wr; r_addr[i] = a; r_data[i] = d;
  endtask

  // one clock: check, retire accepted requests, new random traffic, drive
  task automatic tick();
    @(posedge clk); #1;
    cyc++;
    check_outputs();
    for (int i = 0; i < N; i++) begin
      if (bus.req_ready[i] === 1'b1) begin r_pend[i] = 1'b0; cnt_rdy[i]++; end
      if (bus.rsp_valid[i] === 1'b1) cnt_rsp[i]++;
      if (rand_mode && !r_pend[i] && $urandom_range(0, 2) == 0)
        post(i, 1'($urandom_range(0, 1)), AW'($urandom_range(0, 15)), DW'($urandom));
    end
    drive();
    model_sample();
  endtask

  task automatic run_until(input int i, output int t_rdy, output int t_rsp,
                           output logic [DW-1:0] rd, output logic [AW-1:0] la,
                           output logic [DW-1:0] lw, output logic lwen, output logic lren);
    t_rdy = -1; t_rsp = -1; rd = '0; la = '0; lw = '0; lwen = 1'b0; lren = 1'b0;
    for (int k = 0; k < 40 && t_rsp < 0; k++) begin
      tick();
      if (bus.req_ready[i] === 1'b1) begin
        t_rdy = cyc; la = bus.loc_addr; lw = bus.loc_wdata; lwen = bus.loc_wen; lren = bus.loc_ren;
      end
      if (bus.rsp_valid[i] === 1'b1) begin t_rsp = cyc; rd = bus.rsp_rdata; end
    end
  endtask

  initial begin
    int t0, t_rdy, t_rsp, ng, guard, base;
    int order [6];
    int exp_order [6];
    logic [DW-1:0] rd, lw;
    logic [AW-1:0] la;
    logic lwen, lren;

    for (int i = 0; i < N; i++) begin
      r_pend[i] = 1'b0; r_wr[i] = 1'b0; r_addr[i] = '0; r_data[i] = '0;
      cnt_rdy[i] = 0; cnt_rsp[i] = 0;
    end
    r_rst = 1'b1;
    drive();
    repeat (2) @(posedge clk);
    #1;
    // reset state
    chk("rst_req_ready", bus.req_ready, 64'd0);
    chk("rst_rsp_valid", bus.rsp_valid, 64'd0);
    chk("rst_rsp_rdata", bus.rsp_rdata, 64'd0);
    chk("rst_loc_addr",  bus.loc_addr, 64'd0);
    chk("rst_loc_wen",   bus.loc_wen, 64'd0);
    chk("rst_loc_ren",   bus.loc_ren, 64'd0);
    r_rst = 1'b0;
    drive();
    model_sample();
    repeat (2) tick();

    // single write, requester 0
    post(0, 1'b1, 12'h010, 32'hDEADBEEF);
    tick(); t0 = cyc;
    run_until(0, t_rdy, t_rsp, rd, la, lw, lwen, lren);
    chk("wr_ready_lat", t_rdy, t0 + 1);
    chk("wr_rsp_lat", t_rsp, t0 + 2);
    chk("wr_loc_wen", lwen, 64'd1);
    chk("wr_loc_addr", la, 64'h010);
    chk("wr_loc_wdata", lw, 64'hDEADBEEF);
    chk("wr_rdata_zero", rd, 64'd0);

    // preload then read, requester 1
    post(1, 1'b1, 12'h020, 32'h12345678);
    tick();
    run_until(1, t_rdy, t_rsp, rd, la, lw, lwen, lren);
    post(1, 1'b0, 12'h020, 32'h0);
    tick(); t0 = cyc;
    run_until(1, t_rdy, t_rsp, rd, la, lw, lwen, lren);
    chk("rd_ready_lat", t_rdy, t0 + 1);
    chk("rd_loc_ren", lren, 64'd1);
    chk("rd_rsp_lat", t_rsp, t0 + 2 + RD_LAT);
    chk("rd_data", rd, 64'h12345678);

    // requesters 0 and 1 held valid for six grants
`ifdef LIB_LOCAL_ARB_FIXED_PRIO_EN
    exp_order = '{0, 0, 0, 0, 0, 0};
`else
    exp_order = '{0, 1, 0, 1, 0, 1};
`endif
    post(0, 1'b1, 12'h100, 32'h1);
    post(1, 1'b1, 12'h104, 32'h2);
    ng = 0;
    for (int k = 0; k < 100 && ng < 6; k++) begin
      tick();
      for (int i = 0; i < 2; i++) begin
        if (bus.req_ready[i] === 1'b1 && ng < 6) begin
          order[ng] = i; ng++;
          post(i, 1'b1, 12'h100 + 12'(4 * i), DW'(ng));
        end
      end
    end
    r_pend[0] = 1'b0; r_pend[1] = 1'b0;
    chk("grant_count", ng, 64'd6);
    for (int j = 0; j < 6; j++) chk($sformatf("grant_order_%0d", j), order[j], exp_order[j]);
    repeat (10) tick();

    // wrap: last grant 3, then 1 and 3 together -> 1 then 3
    post(3, 1'b1, 12'h200, 32'h3);
    tick();
    run_until(3, t_rdy, t_rsp, rd, la, lw, lwen, lren);
    post(1, 1'b1, 12'h204, 32'h4);
    post(3, 1'b1, 12'h208, 32'h5);
    ng = 0;
    for (int k = 0; k < 60 && ng < 2; k++) begin
      tick();
      for (int i = 0; i < N; i++) if (bus.req_ready[i] === 1'b1 && ng < 2) begin order[ng] = i; ng++; end
    end
    chk("wrap_first", order[0], 64'd1);
    chk("wrap_second", order[1], 64'd3);
    repeat (10) tick();

    // reset during WAIT of a read
    post(2, 1'b0, 12'h010, 32'h0);
    tick();
    repeat (2) tick();
    r_rst = 1'b1;
    tick();
    r_rst = 1'b0;
    tick();
    chk("mid_rst_ready", bus.req_ready, 64'd0);
    chk("mid_rst_rsp", bus.rsp_valid, 64'd0);
    chk("mid_rst_loc", {bus.loc_wen, bus.loc_ren, bus.loc_addr}, 64'd0);
    chk("mid_rst_rdata", bus.rsp_rdata, 64'd0);
    post(0, 1'b1, 12'h030, 32'hCAFE0001);
    tick(); t0 = cyc;
    run_until(0, t_rdy, t_rsp, rd, la, lw, lwen, lren);
    chk("post_rst_ready", t_rdy, t0 + 1);
    chk("post_rst_rsp", t_rsp, t0 + 2);
    repeat (3) tick();

    // random mixed traffic, 1000 accesses
    for (int i = 0; i < N; i++) begin cnt_rdy[i] = 0; cnt_rsp[i] = 0; end
    base = n_rsp;
    rand_mode = 1'b1;
    guard = 0;
    while (n_rsp - base < 1000 && guard < 60000) begin tick(); guard++; end
    rand_mode = 1'b0;
    chk("rand_done", (n_rsp - base) >= 1000, 64'd1);
    guard = 0;
    while ((r_pend[0] || r_pend[1] || r_pend[2] || r_pend[3] || m_busy) && guard < 300) begin
      tick(); guard++;
    end
    repeat (2) tick();
    for (int i = 0; i < N; i++) chk($sformatf("rsp_per_ready_%0d", i), cnt_rsp[i], cnt_rdy[i]);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
